// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a small prefetch queue.
// Issues one memory read at a time from the fetch PC, uses the BTB to pick
// the next PC, and buffers returned instructions for decode. A redirect
// flushes the queue and any in-flight read is discarded when it returns.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_done,
  input  logic [31:0]               mem_data,
  output logic [ADDR_W-1:0]         btb_pc,
  input  logic                      btb_hit,
  input  logic [ADDR_W-1:0]         btb_pred,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         out_pc,
  output logic [31:0]               out_inst,
  output logic                      out_pred_taken,
  output logic [ADDR_W-1:0]         out_pred_pc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] fpc, fpc_nx;
  logic [ADDR_W-1:0] req_addr;
  logic [PTR_W-1:0]  head, tail;
  logic              push, pop, flush, issue;
  logic              has_entry;
  logic [ADDR_W-1:0] seq_pc, next_fetch;

  logic [ADDR_W-1:0] pc_q    [QDEPTH];
  logic [31:0]       inst_q  [QDEPTH];
  logic              taken_q [QDEPTH];
  logic [ADDR_W-1:0] pred_q  [QDEPTH];

  assign btb_pc     = fpc;
  assign seq_pc     = fpc + ADDR_W'(4);
  assign next_fetch = btb_hit ? btb_pred : seq_pc;
  assign has_entry  = (q_count != '0);
  assign out_valid  = has_entry & ~redirect;
  assign pop        = out_valid & out_ready;

  // Fetch control: decides issue, push, flush and the next fetch PC.
  // The issue path is gated by rst so no request leaks out during reset.
  always_comb begin
    state_nx = state;
    fpc_nx   = fpc;
    mem_req  = 1'b0;
    mem_addr = '0;
    push     = 1'b0;
    flush    = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (redirect) begin
          flush  = 1'b1;
          fpc_nx = redirect_pc;
        end else if (rst && (q_count < CNT_W'(QDEPTH))) begin
          mem_req  = 1'b1;
          mem_addr = fpc;
          issue    = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (redirect) begin
          flush    = 1'b1;
          fpc_nx   = redirect_pc;
          state_nx = mem_done ? IDLE : DISCARD;
        end else if (mem_done) begin
          push     = 1'b1;
          fpc_nx   = next_fetch;
          state_nx = IDLE;
        end
      end
      DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (redirect) begin
          flush  = 1'b1;
          fpc_nx = redirect_pc;
        end
        if (mem_done) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, fetch PC, outstanding address and queue bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      req_addr <= '0;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
    end else begin
      state <= state_nx;
      fpc   <= fpc_nx;
      if (issue) begin
        req_addr <= fpc;
      end
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        q_count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PTR_W'(1);
        end
        if (pop) begin
          head <= head + PTR_W'(1);
        end
        if (push && !pop) begin
          q_count <= q_count + CNT_W'(1);
        end else if (pop && !push) begin
          q_count <= q_count - CNT_W'(1);
        end
      end
    end
  end

  // Queue storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]    <= fpc;
      inst_q[tail]  <= mem_data;
      taken_q[tail] <= btb_hit;
      pred_q[tail]  <= next_fetch;
    end
  end

  assign out_pc         = has_entry ? pc_q[head]    : '0;
  assign out_inst       = has_entry ? inst_q[head]  : '0;
  assign out_pred_taken = has_entry ? taken_q[head] : 1'b0;
  assign out_pred_pc    = has_entry ? pred_q[head]  : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue with default parameters.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic [31:0] btb_pc;
  logic        btb_hit;
  logic [31:0] btb_pred;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_pred_taken;
  logic [31:0] out_pred_pc;
  logic [2:0]  q_count;

  int tests_run;
  int tests_failed;

  if_fetch_queue #(
    .ADDR_W  (32),
    .QDEPTH  (4),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_done      (mem_done),
    .mem_data      (mem_data),
    .btb_pc        (btb_pc),
    .btb_hit       (btb_hit),
    .btb_pred      (btb_pred),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_pred_taken(out_pred_taken),
    .out_pred_pc   (out_pred_pc),
    .q_count       (q_count)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] instOf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic ordy);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = ordy;
  endtask

  // Entered one step after a rising edge with the DUT in IDLE and able to
  // issue; returns one step after the edge that pushes the word.
  task automatic fetchWord(input logic [31:0] addr, input int waits);
    #1;
    checkOutput("issue_req", 64'(mem_req), 64'd1);
    checkOutput("issue_addr", 64'(mem_addr), 64'(addr));
    tick();
    for (int i = 0; i < waits; i++) begin
      #1;
      checkOutput("wait_addr", 64'(mem_addr), 64'(addr));
      tick();
    end
    mem_done = 1'b1;
    mem_data = instOf(addr);
    #1;
    checkOutput("done_addr", 64'(mem_addr), 64'(addr));
    tick();
    mem_done = 1'b0;
    mem_data = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    mem_done     = 1'b0;
    mem_data     = '0;
    btb_hit      = 1'b0;
    btb_pred     = '0;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset state
    tick();
    tick();
    #1;
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_q_count", 64'(q_count), 64'd0);
    checkOutput("rst_btb_pc", 64'(btb_pc), 64'd0);
    checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
    checkOutput("rst_out_inst", 64'(out_inst), 64'd0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Sequential fetch 0,4,8 with decode always ready
    fetchWord(32'h0, 1);
    #1;
    checkOutput("seq0_count", 64'(q_count), 64'd1);
    checkOutput("seq0_valid", 64'(out_valid), 64'd1);
    checkOutput("seq0_pc", 64'(out_pc), 64'h0);
    checkOutput("seq0_inst", 64'(out_inst), 64'(instOf(32'h0)));
    checkOutput("seq0_taken", 64'(out_pred_taken), 64'd0);
    checkOutput("seq0_pred", 64'(out_pred_pc), 64'h4);
    checkOutput("seq0_btb_pc", 64'(btb_pc), 64'h4);
    fetchWord(32'h4, 1);
    #1;
    checkOutput("seq4_pc", 64'(out_pc), 64'h4);
    checkOutput("seq4_inst", 64'(out_inst), 64'(instOf(32'h4)));
    checkOutput("seq4_count", 64'(q_count), 64'd1);
    fetchWord(32'h8, 1);
    #1;
    checkOutput("seq8_pc", 64'(out_pc), 64'h8);
    checkOutput("seq8_inst", 64'(out_inst), 64'(instOf(32'h8)));

    // Stall decode until the queue fills
    applyStimulus(1'b0, 32'h0, 1'b0);
    fetchWord(32'hC, 1);
    fetchWord(32'h10, 1);
    fetchWord(32'h14, 1);
    #1;
    checkOutput("full_count", 64'(q_count), 64'd4);
    checkOutput("full_no_req", 64'(mem_req), 64'd0);
    tick();
    #1;
    checkOutput("full_hold_req", 64'(mem_req), 64'd0);
    checkOutput("full_hold_count", 64'(q_count), 64'd4);
    checkOutput("full_head", 64'(out_pc), 64'h8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("full_ready_valid", 64'(out_valid), 64'd1);
    checkOutput("full_ready_req", 64'(mem_req), 64'd0);
    tick();
    #1;
    checkOutput("resume_count", 64'(q_count), 64'd3);
    checkOutput("resume_req", 64'(mem_req), 64'd1);
    checkOutput("resume_addr", 64'(mem_addr), 64'h18);
    checkOutput("resume_head", 64'(out_pc), 64'hC);
    tick();
    #1;
    checkOutput("drain_head1", 64'(out_pc), 64'h10);
    checkOutput("drain_count1", 64'(q_count), 64'd2);
    checkOutput("drain_addr1", 64'(mem_addr), 64'h18);
    tick();
    #1;
    checkOutput("drain_head2", 64'(out_pc), 64'h14);
    checkOutput("drain_inst2", 64'(out_inst), 64'(instOf(32'h14)));
    tick();
    #1;
    checkOutput("empty_valid", 64'(out_valid), 64'd0);
    checkOutput("empty_count", 64'(q_count), 64'd0);
    checkOutput("empty_pc", 64'(out_pc), 64'd0);
    checkOutput("empty_inst", 64'(out_inst), 64'd0);
    checkOutput("empty_req", 64'(mem_req), 64'd1);
    checkOutput("empty_addr", 64'(mem_addr), 64'h18);
    mem_done = 1'b1;
    mem_data = instOf(32'h18);
    tick();
    mem_done = 1'b0;
    mem_data = '0;
    #1;
    checkOutput("late_count", 64'(q_count), 64'd1);
    checkOutput("late_pc", 64'(out_pc), 64'h18);
    checkOutput("late_pred", 64'(out_pred_pc), 64'h1C);

    // Redirect from IDLE to 0x8, then BTB hit predicting 0x100
    applyStimulus(1'b1, 32'h8, 1'b1);
    #1;
    checkOutput("idle_rd_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_rd_req", 64'(mem_req), 64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    btb_hit  = 1'b1;
    btb_pred = 32'h100;
    #1;
    checkOutput("idle_rd_count", 64'(q_count), 64'd0);
    checkOutput("btb_lookup_pc", 64'(btb_pc), 64'h8);
    fetchWord(32'h8, 0);
    btb_hit  = 1'b0;
    btb_pred = '0;
    #1;
    checkOutput("btb_entry_pc", 64'(out_pc), 64'h8);
    checkOutput("btb_entry_taken", 64'(out_pred_taken), 64'd1);
    checkOutput("btb_entry_pred", 64'(out_pred_pc), 64'h100);
    checkOutput("btb_next_fpc", 64'(btb_pc), 64'h100);
    fetchWord(32'h100, 0);
    #1;
    checkOutput("tgt_entry_pc", 64'(out_pc), 64'h100);
    checkOutput("tgt_entry_pred", 64'(out_pred_pc), 64'h104);

    // Redirect while a read is outstanding; the late data is dropped
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rdw_issue_addr", 64'(mem_addr), 64'h104);
    tick();
    applyStimulus(1'b1, 32'h200, 1'b0);
    #1;
    checkOutput("rdw_valid_mask", 64'(out_valid), 64'd0);
    checkOutput("rdw_req", 64'(mem_req), 64'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rdw_flush_count", 64'(q_count), 64'd0);
    checkOutput("rdw_flush_valid", 64'(out_valid), 64'd0);
    checkOutput("rdw_hold_addr", 64'(mem_addr), 64'h104);
    checkOutput("rdw_new_fpc", 64'(btb_pc), 64'h200);
    tick();
    #1;
    checkOutput("rdw_hold_addr2", 64'(mem_addr), 64'h104);
    tick();
    mem_done = 1'b1;
    mem_data = instOf(32'h104);
    tick();
    mem_done = 1'b0;
    mem_data = '0;
    #1;
    checkOutput("rdw_dropped_count", 64'(q_count), 64'd0);
    checkOutput("rdw_next_req", 64'(mem_req), 64'd1);
    checkOutput("rdw_next_addr", 64'(mem_addr), 64'h200);

    // Redirect and completion in the same cycle
    tick();
    applyStimulus(1'b1, 32'h300, 1'b1);
    mem_done = 1'b1;
    mem_data = instOf(32'h200);
    #1;
    checkOutput("same_valid", 64'(out_valid), 64'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    mem_done = 1'b0;
    mem_data = '0;
    #1;
    checkOutput("same_count", 64'(q_count), 64'd0);
    checkOutput("same_req", 64'(mem_req), 64'd1);
    checkOutput("same_addr", 64'(mem_addr), 64'h300);

    // Reset in the middle of a read; a stale completion is ignored
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("midrst_req", 64'(mem_req), 64'd0);
    checkOutput("midrst_addr", 64'(mem_addr), 64'd0);
    checkOutput("midrst_fpc", 64'(btb_pc), 64'd0);
    tick();
    rst      = 1'b1;
    mem_done = 1'b1;
    mem_data = instOf(32'h300);
    #1;
    checkOutput("stale_req", 64'(mem_req), 64'd1);
    checkOutput("stale_addr", 64'(mem_addr), 64'd0);
    tick();
    mem_done = 1'b0;
    mem_data = '0;
    #1;
    checkOutput("stale_count", 64'(q_count), 64'd0);
    checkOutput("stale_wait_addr", 64'(mem_addr), 64'd0);
    mem_done = 1'b1;
    mem_data = instOf(32'h0);
    tick();
    mem_done = 1'b0;
    mem_data = '0;
    #1;
    checkOutput("postrst_count", 64'(q_count), 64'd1);
    checkOutput("postrst_inst", 64'(out_inst), 64'(instOf(32'h0)));

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    fetchWord(32'hFFFF_FFFC, 1);
    #1;
    checkOutput("wrap_pc", 64'(out_pc), 64'hFFFF_FFFC);
    checkOutput("wrap_taken", 64'(out_pred_taken), 64'd0);
    checkOutput("wrap_pred", 64'(out_pred_pc), 64'd0);
    checkOutput("wrap_next_addr", 64'(mem_addr), 64'd0);
    checkOutput("wrap_next_req", 64'(mem_req), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
